// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART baud-rate controller.
package uart_pkg;

  localparam int DIV_W         = 11;
  localparam int OS_RATIO      = 16;
  localparam int DEFAULT_DIVSR = 650;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    LOAD = 2'd3
  } baud_state_e;

endpackage

// File: rtl/baud_ctrl_if.sv
// Configuration, line-status and tick bundle between the baud controller and its UART user.
interface baud_ctrl_if #(
  parameter int DIV_W = uart_pkg::DIV_W
);

  logic             cfg_en;
  logic             cfg_wr;
  logic [DIV_W-1:0] cfg_divsr;
  logic             tx_busy;
  logic             rx_busy;
  logic             os_tick;
  logic             bit_tick;
  logic             cfg_ack;
  logic             cfg_pend;
  logic [DIV_W-1:0] active_divsr;

  modport master (
    output cfg_en, cfg_wr, cfg_divsr, tx_busy, rx_busy,
    input  os_tick, bit_tick, cfg_ack, cfg_pend, active_divsr
  );

  modport slave (
    input  cfg_en, cfg_wr, cfg_divsr, tx_busy, rx_busy,
    output os_tick, bit_tick, cfg_ack, cfg_pend, active_divsr
  );

endinterface

// File: rtl/baud_tick_counter.sv
// Programmable divider: emits one tick every divsr+1 enabled clocks, divsr=0 ticks every clock.
module baud_tick_counter #(
  parameter int DIV_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] divsr,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  // >= keeps the counter bounded even if divsr ever shrank under a running count
  assign tick = enable && (count >= divsr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/baud_ctrl.sv
// Baud controller: oversample/bit tick generation with divisor updates deferred to an idle line.
// Optional macro BAUD_CTRL_BITTICK_EN adds the bit counter; otherwise bit_tick is tied low.
module baud_ctrl
  import uart_pkg::*;
#(
  parameter int DIV_W    = uart_pkg::DIV_W,
  parameter int OS_RATIO = uart_pkg::OS_RATIO
) (
  input  logic        clk,
  input  logic        reset,
  baud_ctrl_if.slave  bus
);

  baud_state_e      state, state_nx;
  logic [DIV_W-1:0] active, active_nx;
  logic [DIV_W-1:0] shadow, shadow_nx;
  logic             ack_q, ack_nx;
  logic             cnt_en, cnt_clear, os_tick, line_idle;

  assign line_idle = !bus.tx_busy && !bus.rx_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= OFF;
      active <= DIV_W'(DEFAULT_DIVSR);
      shadow <= '0;
      ack_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      active <= active_nx;
      shadow <= shadow_nx;
      ack_q  <= ack_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    active_nx = active;
    shadow_nx = shadow;
    ack_nx    = 1'b0;
    cnt_en    = (state == RUN) || (state == PEND);
    cnt_clear = (state == OFF) || (state == LOAD) || !bus.cfg_en;

    // LOAD always commits the shadow, even if the block is being disabled this cycle
    if (state == LOAD) begin
      active_nx = shadow;
    end

    if (!bus.cfg_en) begin
      state_nx = OFF;
      if (bus.cfg_wr) begin
        active_nx = bus.cfg_divsr;
        ack_nx    = 1'b1;
      end else if (state == PEND) begin
        active_nx = shadow;
        ack_nx    = 1'b1;
      end
    end else begin
      case (state)
        OFF: begin
          state_nx = RUN;
          if (bus.cfg_wr) begin
            active_nx = bus.cfg_divsr;
            ack_nx    = 1'b1;
          end
        end
        RUN, LOAD: begin
          state_nx = RUN;
          if (bus.cfg_wr) begin
            shadow_nx = bus.cfg_divsr;
            state_nx  = line_idle ? LOAD : PEND;
          end
        end
        PEND: begin
          if (bus.cfg_wr) begin
            shadow_nx = bus.cfg_divsr;
          end
          if (line_idle) begin
            state_nx = LOAD;
          end
        end
        default: state_nx = OFF;
      endcase
    end
  end

  baud_tick_counter #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .divsr  (active),
    .tick   (os_tick)
  );

`ifdef BAUD_CTRL_BITTICK_EN
  localparam int BIT_W = (OS_RATIO > 1) ? $clog2(OS_RATIO) : 1;

  logic [BIT_W-1:0] bit_cnt;
  logic             bit_wrap;

  assign bit_wrap = (bit_cnt == BIT_W'(OS_RATIO - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
    end else if (cnt_clear) begin
      bit_cnt <= '0;
    end else if (os_tick) begin
      bit_cnt <= bit_wrap ? '0 : bit_cnt + BIT_W'(1);
    end
  end

  assign bus.bit_tick = os_tick && bit_wrap;
`else
  assign bus.bit_tick = 1'b0;
`endif

  assign bus.os_tick      = os_tick;
  assign bus.cfg_ack      = ack_q || (state == LOAD);
  assign bus.cfg_pend     = (state == PEND);
  assign bus.active_divsr = active;

endmodule

// File: doc/baud_ctrl.md
BAUD_CTRL -- requirements
Module: baud_ctrl

Interface
REQ-001 Parameter DIV_W, default 11, divisor width; 11 bits covers 9600 baud as the slowest rate (divisor 650).
REQ-002 Parameter OS_RATIO, default 16, oversample ticks per bit period.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cfg_en  input  1  level enable for tick generation.
REQ-006 cfg_wr  input  1  one-cycle divisor write strobe.
REQ-007 cfg_divsr  input  DIV_W  requested divisor; sampled when cfg_wr=1.
REQ-008 tx_busy  input  1  UART transmitter mid-frame.
REQ-009 rx_busy  input  1  UART receiver mid-frame.
REQ-010 os_tick  output  1  one-cycle oversample pulse.
REQ-011 bit_tick  output  1  one-cycle pulse once per OS_RATIO os_ticks.
REQ-012 cfg_ack  output  1  one-cycle pulse when a written divisor becomes active.
REQ-013 cfg_pend  output  1  high while a written divisor awaits idle line.
REQ-014 active_divsr  output  DIV_W  divisor currently in use.

Function
REQ-015 States: OFF, RUN, PEND, LOAD; registered, one transition per clock.
REQ-016 OFF: counters held at 0, os_tick=bit_tick=0; cfg_en=1 -> RUN next cycle.
REQ-017 RUN/PEND: tick counter counts 0..active_divsr; os_tick=1 in the cycle count==active_divsr, counter wraps to 0 same edge; period = active_divsr+1 clocks.
REQ-018 active_divsr=0 -> os_tick high every cycle in RUN/PEND.
REQ-019 Bit counter increments on each os_tick, wraps 0..OS_RATIO-1; bit_tick coincides with the os_tick that wraps it.
REQ-020 cfg_wr in OFF: active_divsr <= cfg_divsr next edge, cfg_ack pulses that same next cycle.
REQ-021 cfg_wr in RUN with tx_busy=rx_busy=0: go LOAD; cfg_wr with either busy: latch shadow, go PEND, cfg_pend=1.
REQ-022 cfg_wr in PEND: shadow overwritten; last write wins; no ack for superseded values.
REQ-023 PEND -> LOAD in the first cycle both busy inputs are 0.
REQ-024 LOAD (exactly one cycle): active_divsr <= shadow, both counters cleared, cfg_ack=1, cfg_pend=0, no ticks; then RUN.
REQ-025 cfg_en=0 in any state -> OFF next edge, counters cleared; a pending shadow is applied on that edge with cfg_ack.
REQ-026 cfg_wr and cfg_en falling in the same cycle: the new cfg_divsr is applied directly, ack once.
REQ-027 Divisor arithmetic unsigned, DIV_W bits; counter never exceeds active_divsr.

Reset
REQ-028 reset=0 forces OFF, counters=0, active_divsr=DEFAULT 650, shadow=0, all 1-bit outputs 0, asynchronously.
REQ-029 Reset deassertion mid-operation resumes from OFF; no tick in the first cycle after release.

Configuration
REQ-030 Macro BAUD_CTRL_BITTICK_EN defined: bit counter and bit_tick implemented per REQ-019.
REQ-031 Macro undefined: bit counter absent, bit_tick tied 0; os_tick behaviour unchanged.

Structure
REQ-032 Package uart_pkg holds state enum, DIV_W, OS_RATIO, DEFAULT_DIVSR=650.
REQ-033 Sub-module baud_tick_counter implements REQ-017/018 with clear and enable inputs; baud_ctrl holds FSM, shadow, bit counter.

Verification
REQ-034 Reset release, cfg_en=1, no writes -> os_tick every 651 clocks; bit_tick every 10416 clocks.
REQ-035 OFF, cfg_wr divsr=3, then cfg_en=1 -> cfg_ack one cycle after write; os_tick period 4 clocks.
REQ-036 RUN, tx_busy=1, cfg_wr 9 then 5 -> cfg_pend=1; drop tx_busy -> single LOAD, one cfg_ack, active_divsr=5, period 6.
REQ-037 RUN, divsr=0 -> os_tick continuous; bit_tick every 16 clocks; macro undefined -> bit_tick stays 0.
REQ-038 PEND, cfg_en=0 -> OFF, shadow applied with ack, no ticks while OFF.
REQ-039 reset pulsed mid-count -> all outputs 0 immediately, active_divsr=650.
